// File: rtl/spike_if.sv
// Membrane-sum input and spike/readout output bundle for spike_generator.
// master drives the accumulator side, slave is the spike stage.
interface spike_if #(
  parameter int ACC_W    = 23,
  parameter int REFRAC_W = 8,
  parameter int CNT_W    = 16
);
  logic                ce;
  logic [ACC_W-1:0]    acc_y;
  logic [ACC_W-1:0]    threshold;
  logic [REFRAC_W-1:0] refrac_len;
  logic                spike;
  logic                acc_rst;
  logic                refractory;
  logic [CNT_W-1:0]    spike_cnt;

  modport master (
    output ce, acc_y, threshold, refrac_len,
    input  spike, acc_rst, refractory, spike_cnt
  );

  modport slave (
    input  ce, acc_y, threshold, refrac_len,
    output spike, acc_rst, refractory, spike_cnt
  );
endinterface

// File: rtl/spike_generator.sv
// Integrate-and-fire output stage: threshold compare, one-cycle spike,
// refractory hold of the accumulator and a saturating spike counter.
module spike_generator #(
  parameter int ACC_W    = 23,
  parameter int REFRAC_W = 8,
  parameter int CNT_W    = 16
) (
  input logic  clk,
  input logic  rst,
  spike_if.slave bus
);
  typedef enum logic [1:0] {
    INTEG,
    FIRE,
    REFRAC
  } state_t;

  state_t              state;
  state_t              nxt;
  logic [REFRAC_W-1:0] rcnt;
  logic [CNT_W-1:0]    cnt;
  logic                spike_q;
  logic                acc_rst_q;
  logic                refr_q;
  logic                hit;

  assign hit = $signed(bus.acc_y) >= $signed(bus.threshold);

  always_comb begin
    nxt = state;
    unique case (state)
      INTEG:   if (hit) nxt = FIRE;
      FIRE:    nxt = (rcnt == '0) ? INTEG : REFRAC;
      REFRAC:  if (rcnt == REFRAC_W'(1)) nxt = INTEG;
      default: nxt = INTEG;
    endcase
  end

  // Outputs decode the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INTEG;
      rcnt      <= '0;
      cnt       <= '0;
      spike_q   <= 1'b0;
      acc_rst_q <= 1'b1;
      refr_q    <= 1'b0;
    end else if (bus.ce) begin
      state     <= nxt;
      spike_q   <= (nxt == FIRE);
      acc_rst_q <= (nxt != INTEG);
      refr_q    <= (nxt == REFRAC);
      if (state == INTEG && nxt == FIRE) begin
        rcnt <= bus.refrac_len;
        if (cnt != '1) cnt <= cnt + CNT_W'(1);
      end else if (state == REFRAC && rcnt != '0) begin
        rcnt <= rcnt - REFRAC_W'(1);
      end
    end
  end

  assign bus.spike      = spike_q;
  assign bus.acc_rst    = acc_rst_q;
  assign bus.refractory = refr_q;
  assign bus.spike_cnt  = cnt;
endmodule

// File: tb/tb_spike_generator.sv
// Directed bench for spike_generator with an expected-value scoreboard;
// a second instance with a 4-bit counter covers saturation.
module tb_spike_generator;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  typedef struct {
    logic s;
    logic a;
    logic r;
    int   c;
    int   c4;
  } exp_t;

  exp_t sb[$];

  spike_if #(.ACC_W(23), .REFRAC_W(8), .CNT_W(16)) bus ();
  spike_if #(.ACC_W(23), .REFRAC_W(8), .CNT_W(4))  sbus ();

  spike_generator #(.ACC_W(23), .REFRAC_W(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spike_generator #(.ACC_W(23), .REFRAC_W(8), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic c, input logic r,
                      input int y, input int th, input int rl,
                      input logic es, input logic ea, input logic er,
                      input int ec);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst             = r;
    bus.ce          = c;
    bus.acc_y       = 23'(y);
    bus.threshold   = 23'(th);
    bus.refrac_len  = 8'(rl);
    sbus.ce         = c;
    sbus.acc_y      = 23'(y);
    sbus.threshold  = 23'(th);
    sbus.refrac_len = 8'(rl);
    e.s  = es;
    e.a  = ea;
    e.r  = er;
    e.c  = ec;
    e.c4 = (ec > 15) ? 15 : ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({tag, ".spike"}, 32'(bus.spike), 32'(g.s));
    chk({tag, ".acc_rst"}, 32'(bus.acc_rst), 32'(g.a));
    chk({tag, ".refractory"}, 32'(bus.refractory), 32'(g.r));
    chk({tag, ".spike_cnt"}, 32'(bus.spike_cnt), 32'(g.c));
    chk({tag, ".spike4"}, 32'(sbus.spike), 32'(g.s));
    chk({tag, ".spike_cnt4"}, 32'(sbus.spike_cnt), 32'(g.c4));
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.ce          = 1'b1;
    bus.acc_y       = '0;
    bus.threshold   = '0;
    bus.refrac_len  = '0;
    sbus.ce         = 1'b1;
    sbus.acc_y      = '0;
    sbus.threshold  = '0;
    sbus.refrac_len = '0;

    // reset, then acc_rst drops one edge after rst falls
    step("rst0", 1, 1, 0, 1000, 3, 0, 1, 0, 0);
    step("rst1", 1, 1, 0, 1000, 3, 0, 1, 0, 0);
    step("rel",  1, 0, 0, 1000, 3, 0, 0, 0, 0);

    // ramp crossing, refrac 3, mid-refrac threshold change ignored
    step("r400",  1, 0, 400,  1000, 3, 0, 0, 0, 0);
    step("r800",  1, 0, 800,  1000, 3, 0, 0, 0, 0);
    step("r1200", 1, 0, 1200, 1000, 3, 1, 1, 0, 1);
    step("ref1",  1, 0, 0,    1000, 3, 0, 1, 1, 1);
    step("ref2",  1, 0, 0,    -5,   3, 0, 1, 1, 1);
    step("ref3",  1, 0, 0,    -5,   3, 0, 1, 1, 1);
    step("out",   1, 0, 0,    -5,   3, 0, 0, 0, 1);

    // negative threshold fires right away, refrac_len sampled at entry
    step("neg_f", 1, 0, 0, -5, 1, 1, 1, 0, 2);
    step("neg_r", 1, 0, 0, -5, 9, 0, 1, 1, 2);
    step("neg_o", 1, 0, 0, -5, 9, 0, 0, 0, 2);

    // equality and sign
    step("lt_neg", 1, 0, -60, -50, 0, 0, 0, 0, 2);
    step("eq_neg", 1, 0, -50, -50, 0, 1, 1, 0, 3);
    step("eq_out", 1, 0, 'h400000, 'h3FFFFF, 0, 0, 0, 0, 3);
    step("minmax", 1, 0, 'h400000, 'h3FFFFF, 0, 0, 0, 0, 3);
    step("minmx2", 1, 0, 'h400000, 'h3FFFFF, 0, 0, 0, 0, 3);

    // zero refractory: FIRE and INTEG alternate
    step("z0f", 1, 0, 100, 100, 0, 1, 1, 0, 4);
    step("z0i", 1, 0, 100, 100, 0, 0, 0, 0, 4);
    step("z1f", 1, 0, 100, 100, 0, 1, 1, 0, 5);
    step("z1i", 1, 0, 100, 100, 0, 0, 0, 0, 5);
    step("z2f", 1, 0, 100, 100, 0, 1, 1, 0, 6);
    step("z2i", 1, 0, 0,   100, 0, 0, 0, 0, 6);

    // ce low during REFRAC stretches it by 5 cycles
    step("cef", 1, 0, 100, 100, 2, 1, 1, 0, 7);
    step("cer", 1, 0, 0,   100, 2, 0, 1, 1, 7);
    for (int i = 0; i < 5; i++)
      step("hold", 0, 0, 500, 100, 0, 0, 1, 1, 7);
    step("cer2", 1, 0, 0, 100, 2, 0, 1, 1, 7);
    step("ceo",  1, 0, 0, 100, 2, 0, 0, 0, 7);

    // reset inside REFRAC
    step("mrf", 1, 0, 100, 100, 5, 1, 1, 0, 8);
    step("mr1", 1, 0, 0,   100, 5, 0, 1, 1, 8);
    step("mr2", 1, 0, 0,   100, 5, 0, 1, 1, 8);
    step("mrr", 1, 1, 0,   100, 5, 0, 1, 0, 0);
    step("mro", 1, 0, 0,   100, 5, 0, 0, 0, 0);

    // reset wins over a crossing on the same edge
    step("rwc", 1, 1, 100, 100, 5, 0, 1, 0, 0);
    step("rwo", 1, 0, 0,   100, 5, 0, 0, 0, 0);

    // reset inside FIRE: nothing counted
    step("rff", 1, 0, 100, 100, 5, 1, 1, 0, 1);
    step("rfr", 1, 1, 0,   100, 5, 0, 1, 0, 0);
    step("rfo", 1, 0, 0,   100, 5, 0, 0, 0, 0);

    // saturation on the 4-bit counter, pulses keep coming
    for (int i = 0; i < 20; i++) begin
      step("satf", 1, 0, 100, 100, 0, 1, 1, 0, i + 1);
      step("sati", 1, 0, 100, 100, 0, 0, 0, 0, i + 1);
    end

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
